// File: rtl/leading_run_counter.sv
// Two-stage leading-run counter: per-chunk leading counts, then a prefix combine.
// Optional saturating all_same transfer counter behind LEADING_RUN_COUNTER_PERF_EN.
module leading_run_counter #(
    parameter int N = 16,
    parameter int C = 8,
    parameter int S = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_bits,
    input  logic         in_pol,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [S-1:0] run_len,
    output logic         all_same
`ifdef LEADING_RUN_COUNTER_PERF_EN
    ,
    output logic [31:0]  perf_full
`endif
);

    localparam int K  = N / C;
    localparam int CW = $clog2(C) + 1;

    logic          en;

    logic          s1_valid_q;
    logic          s1_valid_d;
    logic [CW-1:0] s1_cnt_q [K];
    logic [CW-1:0] s1_cnt_d [K];
    logic [K-1:0]  s1_full_q;
    logic [K-1:0]  s1_full_d;

    logic          s2_valid_q;
    logic          s2_valid_d;
    logic [S-1:0]  s2_len_q;
    logic [S-1:0]  s2_len_d;
    logic          s2_all_q;
    logic          s2_all_d;

    logic [S-1:0]  sum;

    function automatic logic [CW-1:0] chunk_lead(
        input logic [C-1:0] bits,
        input logic         pol
    );
        logic [CW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int i = C - 1; i >= 0; i--) begin
            run = run & (bits[i] == pol);
            n   = n + {{(CW-1){1'b0}}, run};
        end
        return n;
    endfunction

    assign en        = !s2_valid_q || out_ready;
    // Reset forces ready high; the reset branch below discards the offered word.
    assign in_ready  = en || rst;
    assign out_valid = s2_valid_q;
    assign run_len   = s2_len_q;
    assign all_same  = s2_all_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cnt_d   = s1_cnt_q;
        s1_full_d  = s1_full_q;
        if (en) begin
            s1_valid_d = in_valid;
            for (int k = 0; k < K; k++) begin
                s1_cnt_d[k]  = chunk_lead(in_bits[N-1-k*C -: C], in_pol);
                s1_full_d[k] = (s1_cnt_d[k] == CW'(C));
            end
        end
    end

    // Sum chunk counts up to and including the first chunk that is not full.
    always_comb begin
        logic go;
        sum = '0;
        go  = 1'b1;
        for (int k = 0; k < K; k++) begin
            if (go) begin
                sum = sum + S'(s1_cnt_q[k]);
            end
            go = go & s1_full_q[k];
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_len_d   = s2_len_q;
        s2_all_d   = s2_all_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_len_d   = sum;
            s2_all_d   = (sum == S'(N));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_full_q  <= '0;
            for (int k = 0; k < K; k++) begin
                s1_cnt_q[k] <= '0;
            end
            s2_valid_q <= 1'b0;
            s2_len_q   <= '0;
            s2_all_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_full_q  <= s1_full_d;
            s1_cnt_q   <= s1_cnt_d;
            s2_valid_q <= s2_valid_d;
            s2_len_q   <= s2_len_d;
            s2_all_q   <= s2_all_d;
        end
    end

`ifdef LEADING_RUN_COUNTER_PERF_EN
    logic [31:0] perf_q;
    logic [31:0] perf_d;

    always_comb begin
        perf_d = perf_q;
        if (s2_valid_q && out_ready && s2_all_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_full = perf_q;
`endif

endmodule

// File: doc/leading_run_counter.md
LEADING_RUN_COUNTER -- requirements
Module: leading_run_counter

Interface
REQ-001 SHALL have parameter N, default 16: input word width; N >= 2, multiple of C.
REQ-002 SHALL have parameter C, default 8: chunk width for stage-1 partial counts; power of two, 2..N.
REQ-003 SHALL have parameter S, default $clog2(N)+1: width of run_len; a run of exactly N is representable.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  source offers a word.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port in_bits  input  N  word to scan, MSB first.
REQ-009 SHALL have port in_pol  input  1  run polarity: 1 counts leading ones, 0 counts leading zeros.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  sink takes the result.
REQ-012 SHALL have port run_len  output  S  consecutive MSB-side bits equal to in_pol, 0..N.
REQ-013 SHALL have port all_same  output  1  high when run_len == N.

Function
REQ-014 SHALL accept a word when in_valid && in_ready (transfer).
REQ-015 SHALL complete a transfer when out_valid && out_ready.
REQ-016 SHALL be a two-stage pipeline (S1 per-chunk count, S2 combine); latency exactly 2 cycles from input transfer to out_valid with no stall.
REQ-017 S1 SHALL register, per chunk k (chunk 0 = MSB chunk), the leading count of bits equal to in_pol (0..C) and a chunk-full flag.
REQ-018 S2 SHALL output the sum of counts of chunks 0..j, where j is the first non-full chunk (all chunks if none are full-free).
REQ-019 Stall enable SHALL be: en = !out_valid || out_ready; stages advance only when en is high.
REQ-020 in_ready SHALL equal en (combinational); full throughput of 1 word/cycle when out_ready is held high.
REQ-021 While out_valid && !out_ready, run_len, all_same and out_valid SHALL hold stable.
REQ-022 Empty bubbles SHALL propagate as valid=0; the data registers of a bubble stage are don't-care.
REQ-023 Per-word in_pol SHALL travel with its data; mixed polarities back-to-back SHALL be correct.
REQ-024 Boundaries: in_bits all equal to in_pol -> run_len=N, all_same=1; MSB != in_pol -> run_len=0, all_same=0.
REQ-025 A simultaneous input transfer and output transfer in the same cycle SHALL lose no word.

Reset
REQ-026 rst high at a clock edge SHALL clear all stage valid bits; out_valid=0, run_len=0, all_same=0 on the next cycle.
REQ-027 Words in flight at reset SHALL be discarded and never emitted.
REQ-028 During reset in_ready SHALL be 1, but no transfer SHALL be recorded while rst is high.

Configuration
REQ-029 Macro LEADING_RUN_COUNTER_PERF_EN defined: the block SHALL add output perf_full (32-bit), counting output transfers with all_same=1, saturating at 32'hFFFFFFFF, cleared by rst.
REQ-030 Macro undefined: perf_full port and counter SHALL be absent; all other behaviour is identical.

Verification (N=16, C=8 unless stated)
REQ-031 in_bits=16'hE5FF, pol=1, out_ready=1 -> 2 cycles later run_len=3, all_same=0.
REQ-032 in_bits=16'h0010, pol=0 -> run_len=11; then 16'hFFFF pol=1 -> run_len=16, all_same=1; then 16'hFFFF pol=0 -> run_len=0.
REQ-033 Chunk boundary: 16'hFF7F pol=1 -> run_len=8; 16'h00FF pol=0 -> run_len=8; 16'h0000 pol=0 -> run_len=16.
REQ-034 Backpressure: stream 4 words with out_ready=0 for 3 cycles -> in_ready drops, out_valid held with the first result stable; on release all 4 results emerge in order with none lost or duplicated.
REQ-035 Reset mid-flight: 2 words accepted, rst asserted 1 cycle -> out_valid=0 next cycle, neither word is ever emitted, and the next word after reset yields the correct count.
REQ-036 With LEADING_RUN_COUNTER_PERF_EN defined: 5 transfers, 2 with all_same=1 -> perf_full=2; rst -> perf_full=0.
